rr_timer_scheduler: RTL



---
 rtl/rr_timer_pkg.sv | 45 ++++
 rtl/rr_pick.sv | 27 ++
 rtl/rr_timer_scheduler.sv | 112 +++++++++++
 3 files changed

// File: rtl/rr_timer_pkg.sv
// Shared types and helpers for the round-robin timer scheduler.
package rr_timer_pkg;

  // Scheduler phases: waiting for a request, counting, acknowledging.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACK  = 2'd2
  } state_e;

  // Widest requester vector the helpers below understand.
  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IW  = 4;

  // The pointer resets to the highest index so that the very first
  // search starts at requester 0.
  localparam int unsigned LAST_PTR_RST_OFFSET = 1;

  function automatic int unsigned last_ptr_rst(input int unsigned n_req);
    return n_req - LAST_PTR_RST_OFFSET;
  endfunction

  // Winner is the first set bit searching upward from last_ptr+1, wrapping
  // modulo n_req. Returns 0 when nothing is requested.
  function automatic logic [MAX_IW-1:0] next_rr(input logic [MAX_REQ-1:0] req,
                                                input logic [MAX_IW-1:0]  last_ptr,
                                                input int unsigned        n_req);
    logic [MAX_IW-1:0] win;
    logic              found;
    logic [31:0]       idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= MAX_REQ; off++) begin
      if (off <= n_req) begin
        idx = (32'(last_ptr) + off) % n_req;
        if (!found && req[idx[MAX_IW-1:0]]) begin
          win   = idx[MAX_IW-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester after last_ptr wins.
module rr_pick
  import rr_timer_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  logic [MAX_IW-1:0] win_full;

  // Rotate-and-search through the shared helper, then narrow to IW bits.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    win_full = '0;
    win_full = next_rr(MAX_REQ'(req), MAX_IW'(last_ptr), N);
  end

  assign winner = win_full[IW-1:0];
  assign any    = |req;

endmodule

// File: rtl/rr_timer_scheduler.sv
// Round-robin sharing of one down-counting timer among N_REQ requesters.
module rr_timer_scheduler
  import rr_timer_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned IW    = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] dur,
  output logic               busy,
  output logic               grant_vld,
  output logic [IW-1:0]      grant_id,
  output logic [W-1:0]       count,
  output logic [N_REQ-1:0]   done_pulse
);

  localparam logic [IW-1:0] LAST_PTR_RST = IW'(last_ptr_rst(N_REQ));

  state_e        state_q, state_d;
  logic [W-1:0]  count_q, count_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_ptr_q, last_ptr_d;

  logic [IW-1:0] winner;
  logic          any_req;
  logic [W-1:0]  dur_sel;

  rr_pick #(
    .N  (N_REQ),
    .IW (IW)
  ) u_pick (
    .req      (req),
    .last_ptr (last_ptr_q),
    .winner   (winner),
    .any      (any_req)
  );

  // Select the winning requester's duration lane.
  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == IW'(i)) dur_sel = dur[i*W +: W];
    end
  end

  // State, timer and pointer registers; reset drops any pending interval.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      grant_q    <= '0;
      last_ptr_q <= LAST_PTR_RST;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
    end
  end

  // Next-state logic: grant, count down, acknowledge; cancel beats expiry.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = RUN;
          grant_d = winner;
          count_d = dur_sel;
        end
      end
      RUN: begin
        if (!req[grant_q]) begin
          state_d    = IDLE;
          last_ptr_d = grant_q;
          count_d    = '0;
        end else if (count_q == '0) begin
          state_d = ACK;
        end else begin
          count_d = count_q - W'(1);
        end
      end
      ACK: begin
        state_d    = IDLE;
        last_ptr_d = grant_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore done pulse: one-hot on the granted requester during ACK only.
  always_comb begin
    done_pulse = '0;
    if (state_q == ACK) done_pulse[grant_q] = 1'b1;
  end

  assign busy      = (state_q != IDLE);
  assign grant_vld = (state_q == RUN);
  assign grant_id  = grant_q;
  assign count     = count_q;

endmodule
